// File: rtl/asm_mon_pkg.sv
// Shared types and default widths for the assembly-test result monitor.
// Optional behaviour elsewhere is selected by ASM_MON_ALL_CHECKS_EN.
package asm_mon_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned NUM_CHECKS_DEF = 8;
  localparam int unsigned TIMEOUT_DEF    = 100;

  localparam int unsigned RA = $clog2(NUM_REGS_DEF);
  localparam int unsigned CI = $clog2(NUM_CHECKS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    CHECK,
    PASS,
    FAIL,
    TIMEOUT
  } mon_state_t;

  typedef struct packed {
    logic [RA-1:0]       rsel;
    logic [XLEN_DEF-1:0] val;
  } check_entry_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/asm_mon_shadow_rf.sv
// Shadow copy of the CPU register file, fed by snooping the writeback port.
// x0 reads as zero; writes are dropped while freeze_i is high.
module asm_mon_shadow_rf #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        freeze_i,
  input  logic                        wb_en_i,
  input  logic [$clog2(NUM_REGS)-1:0] wb_addr_i,
  input  logic [XLEN-1:0]             wb_data_i,
  input  logic [$clog2(NUM_REGS)-1:0] trig_addr_i,
  output logic [XLEN-1:0]             trig_data_o,
  input  logic [$clog2(NUM_REGS)-1:0] chk_addr_i,
  output logic [XLEN-1:0]             chk_data_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wb_en_i && !freeze_i && (wb_addr_i != '0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_comb begin
    trig_data_o = (trig_addr_i == '0) ? '0 : regs_q[trig_addr_i];
    chk_data_o  = (chk_addr_i == '0) ? '0 : regs_q[chk_addr_i];
  end

endmodule

// File: rtl/asm_result_monitor.sv
// Assembly-test result checker: arm, wait for trigger register, compare table.
// Define ASM_MON_ALL_CHECKS_EN to run every entry and expose fail_mask.
module asm_result_monitor
  import asm_mon_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEF,
  parameter int unsigned NUM_REGS       = NUM_REGS_DEF,
  parameter int unsigned NUM_CHECKS     = NUM_CHECKS_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_en,
  input  logic [$clog2(NUM_REGS)-1:0]   wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
  input  logic [$clog2(NUM_REGS)-1:0]   cfg_reg,
  input  logic [XLEN-1:0]               cfg_val,
  input  logic [$clog2(NUM_CHECKS):0]   cfg_num,
  input  logic [$clog2(NUM_REGS)-1:0]   trig_reg,
  input  logic [XLEN-1:0]               trig_val,
  input  logic                          start,
`ifdef ASM_MON_ALL_CHECKS_EN
  output logic [NUM_CHECKS-1:0]         fail_mask,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [$clog2(NUM_CHECKS)-1:0] fail_idx,
  output logic [XLEN-1:0]               fail_got
);

  localparam int unsigned RA_W = $clog2(NUM_REGS);
  localparam int unsigned CI_W = $clog2(NUM_CHECKS);
  localparam int unsigned NW   = CI_W + 1;
  localparam int unsigned CW   = clog2_min1(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [RA_W-1:0] rsel;
    logic [XLEN-1:0] val;
  } entry_t;

  mon_state_t      state_q, state_d;
  logic [NW-1:0]   num_q, num_d;
  logic [RA_W-1:0] trig_reg_q, trig_reg_d;
  logic [XLEN-1:0] trig_val_q, trig_val_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CI_W-1:0] idx_q, idx_d;
  logic [CI_W-1:0] fail_idx_q, fail_idx_d;
  logic [XLEN-1:0] fail_got_q, fail_got_d;
  entry_t          tbl_q [NUM_CHECKS];
  logic            tbl_we;
  logic            freeze;
  logic            trig_match;
  logic            mismatch;
  logic            last;
  logic [XLEN-1:0] trig_data;
  logic [XLEN-1:0] chk_data;
`ifdef ASM_MON_ALL_CHECKS_EN
  logic [NUM_CHECKS-1:0] mask_q, mask_d;
`endif

  asm_mon_shadow_rf #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_shadow (
    .clk_i       (clk),
    .rst_ni      (rst),
    .freeze_i    (freeze),
    .wb_en_i     (wb_en),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .trig_addr_i (trig_reg_q),
    .trig_data_o (trig_data),
    .chk_addr_i  (tbl_q[idx_q].rsel),
    .chk_data_o  (chk_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      trig_reg_q <= '0;
      trig_val_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        tbl_q[i] <= '0;
      end
`ifdef ASM_MON_ALL_CHECKS_EN
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      trig_reg_q <= trig_reg_d;
      trig_val_q <= trig_val_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      if (tbl_we) begin
        tbl_q[cfg_idx] <= '{rsel: cfg_reg, val: cfg_val};
      end
`ifdef ASM_MON_ALL_CHECKS_EN
      mask_q     <= mask_d;
`endif
    end
  end

  assign trig_match = (trig_data == trig_val_q);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    trig_reg_d = trig_reg_q;
    trig_val_d = trig_val_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    tbl_we     = 1'b0;
    freeze     = 1'b1;
    mismatch   = (chk_data != tbl_q[idx_q].val);
    last       = ({1'b0, idx_q} == (num_q - 1'b1));
`ifdef ASM_MON_ALL_CHECKS_EN
    mask_d     = mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        freeze = 1'b0;
        tbl_we = cfg_we && (32'(cfg_idx) < NUM_CHECKS);
        if (start) begin
          num_d      = (32'(cfg_num) > NUM_CHECKS) ? NW'(NUM_CHECKS) : cfg_num;
          trig_reg_d = trig_reg;
          trig_val_d = trig_val;
          cnt_d      = '0;
          idx_d      = '0;
          state_d    = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        // Freezing on the match cycle makes the snapshot exactly what matched.
        if (trig_match) begin
          idx_d   = '0;
          state_d = CHECK;
        end else begin
          freeze = 1'b0;
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
            state_d = TIMEOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (num_q == '0) begin
          state_d = PASS;
        end else begin
`ifdef ASM_MON_ALL_CHECKS_EN
          if (mismatch) begin
            mask_d[idx_q] = 1'b1;
            if (mask_q == '0) begin
              fail_idx_d = idx_q;
              fail_got_d = chk_data;
            end
          end
          if (last) begin
            state_d = (mismatch || (mask_q != '0)) ? FAIL : PASS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`else
          if (mismatch) begin
            fail_idx_d = idx_q;
            fail_got_d = chk_data;
            state_d    = FAIL;
          end else if (last) begin
            state_d = PASS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`endif
        end
      end
      PASS, FAIL, TIMEOUT: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q == WAIT_TRIG) || (state_q == CHECK);
    done     = (state_q == PASS) || (state_q == FAIL) || (state_q == TIMEOUT);
    pass     = (state_q == PASS);
    timeout  = (state_q == TIMEOUT);
    fail_idx = fail_idx_q;
    fail_got = fail_got_q;
`ifdef ASM_MON_ALL_CHECKS_EN
    fail_mask = mask_q;
`endif
  end

endmodule

// File: tb/tb_asm_result_monitor.sv
// Scoreboard bench for asm_result_monitor: expectations queued at trigger,
// popped and compared when done rises. Honours ASM_MON_ALL_CHECKS_EN.
module tb_asm_result_monitor;
  import asm_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_val;
  logic [3:0]  cfg_num;
  logic [4:0]  trig_reg;
  logic [31:0] trig_val;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [2:0]  fail_idx;
  logic [31:0] fail_got;
`ifdef ASM_MON_ALL_CHECKS_EN
  logic [7:0]  fail_mask;
`endif

  asm_result_monitor #(
    .XLEN           (32),
    .NUM_REGS       (32),
    .NUM_CHECKS     (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_reg  (cfg_reg),
    .cfg_val  (cfg_val),
    .cfg_num  (cfg_num),
    .trig_reg (trig_reg),
    .trig_val (trig_val),
    .start    (start),
`ifdef ASM_MON_ALL_CHECKS_EN
    .fail_mask(fail_mask),
`endif
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .fail_idx (fail_idx),
    .fail_got (fail_got)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [2:0]  fidx;
    logic [31:0] fgot;
    logic [7:0]  mask;
    int unsigned lat;
    int unsigned done_cyc;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  m_sh [32];
  check_entry_t m_tbl [8];
  int unsigned  m_num;
  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_sh[i] = '0;
    for (int i = 0; i < 8; i++) m_tbl[i] = '0;
    m_num = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; wb_en = 1'b0; cfg_we = 1'b0; start = 1'b0;
    wb_addr = '0; wb_data = '0; cfg_idx = '0; cfg_reg = '0; cfg_val = '0;
    cfg_num = '0; trig_reg = '0; trig_val = '0;
    tick();
    tick();
    rst = 1'b1;
    model_clear();
    exp_q.delete();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
    if (a != 5'd0) m_sh[a] = d;
  endtask

  task automatic cfg(input logic [2:0] i, input logic [4:0] r, input logic [31:0] v);
    cfg_we = 1'b1; cfg_idx = i; cfg_reg = r; cfg_val = v;
    tick();
    cfg_we = 1'b0;
    m_tbl[i] = '{rsel: r, val: v};
  endtask

  task automatic arm(input logic [3:0] n, input logic [4:0] tr, input logic [31:0] tv,
                     output int unsigned s);
    cfg_num = n; trig_reg = tr; trig_val = tv; start = 1'b1;
    tick();
    start = 1'b0;
    m_num = n;
    s = cyc;
  endtask

  function automatic exp_t model_eval(input int unsigned num);
    exp_t        e;
    int unsigned n;
    logic [31:0] got;
    bit          stop;
    n = (num > 8) ? 8 : num;
    e.pass = 1'b1; e.tmo = 1'b0; e.fidx = '0; e.fgot = '0; e.mask = '0;
    e.lat = (n == 0) ? 1 : n;
    e.done_cyc = 0;
    stop = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      if (!stop) begin
        got = (m_tbl[i].rsel == 5'd0) ? 32'd0 : m_sh[m_tbl[i].rsel];
        if (got != m_tbl[i].val) begin
          if (e.pass) begin
            e.pass = 1'b0;
            e.fidx = 3'(i);
            e.fgot = got;
          end
          e.mask[i] = 1'b1;
`ifndef ASM_MON_ALL_CHECKS_EN
          e.lat = i + 1;
          stop  = 1'b1;
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic wb_trig(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    wb(a, d);
    e = model_eval(m_num);
    e.done_cyc = cyc + 1 + e.lat;
    exp_q.push_back(e);
  endtask

  task automatic push_timeout(input int unsigned s);
    exp_t e;
    e.pass = 1'b0; e.tmo = 1'b1; e.fidx = '0; e.fgot = '0; e.mask = '0;
    e.lat = 0; e.done_cyc = s + 100;
    exp_q.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    exp_t        e;
    int unsigned k = 0;
    while (done !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_sb_pending"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_pass"}, 64'(pass), 64'(e.pass));
      check_eq({tag, "_timeout"}, 64'(timeout), 64'(e.tmo));
      check_eq({tag, "_fail_idx"}, 64'(fail_idx), 64'(e.fidx));
      check_eq({tag, "_fail_got"}, 64'(fail_got), 64'(e.fgot));
      check_eq({tag, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
`ifdef ASM_MON_ALL_CHECKS_EN
      check_eq({tag, "_fail_mask"}, 64'(fail_mask), 64'(e.mask));
`endif
    end
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_pass"}, 64'(pass), 64'd0);
    check_eq({tag, "_timeout"}, 64'(timeout), 64'd0);
    check_eq({tag, "_fail_idx"}, 64'(fail_idx), 64'd0);
    check_eq({tag, "_fail_got"}, 64'(fail_got), 64'd0);
`ifdef ASM_MON_ALL_CHECKS_EN
    check_eq({tag, "_fail_mask"}, 64'(fail_mask), 64'd0);
`endif
  endtask

  task automatic basic_setup(input logic [31:0] x13_val, output int unsigned s);
    do_reset();
    cfg(3'd0, 5'd25, 32'd0);
    cfg(3'd1, 5'd13, 32'd1);
    arm(4'd2, 5'd20, 32'd1, s);
    wb(5'd13, x13_val);
    wb(5'd25, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;

    do_reset();
    check_idle_outputs("reset");

    // Basic pass: PASS two cycles after trigger detection.
    basic_setup(32'd1, s);
    wb_trig(5'd20, 32'd1);
    wait_result("basic");

    // First fail, then the result must hold against later writes and start.
    basic_setup(32'd5, s);
    wb_trig(5'd20, 32'd1);
    wait_result("first_fail");
    wb(5'd13, 32'd9);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("fail_hold_got", 64'(fail_got), 64'd5);
    check_eq("fail_hold_idx", 64'(fail_idx), 64'd1);
    check_eq("fail_hold_done", 64'(done), 64'd1);
    check_eq("fail_hold_busy", 64'(busy), 64'd0);

    // Timeout with the trigger never written.
    basic_setup(32'd1, s);
    push_timeout(s);
    wait_result("timeout");

    // Trigger write lands in the last allowed cycle: match beats timeout.
    basic_setup(32'd1, s);
    while (cyc < s + 98) tick();
    wb_trig(5'd20, 32'd1);
    wait_result("late_trig");

    // x0 ignores writes; a write right after trigger does not reach CHECK.
    do_reset();
    cfg(3'd0, 5'd0, 32'd0);
    cfg(3'd1, 5'd5, 32'd3);
    arm(4'd2, 5'd20, 32'd1, s);
    wb(5'd0, 32'd7);
    wb(5'd5, 32'd3);
    wb_trig(5'd20, 32'd1);
    wb(5'd5, 32'd99);
    wait_result("x0_freeze");

    // cfg_num saturation, cfg+start in one cycle, cfg ignored while armed.
    do_reset();
    for (int i = 0; i < 7; i++) cfg(3'(i), 5'(i + 1), 32'(i * 3 + 1));
    cfg_we = 1'b1; cfg_idx = 3'd7; cfg_reg = 5'd8; cfg_val = 32'd100;
    cfg_num = 4'd12; trig_reg = 5'd20; trig_val = 32'hABCD; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    m_tbl[7] = '{rsel: 5'd8, val: 32'd100};
    m_num = 12;
    for (int i = 0; i < 7; i++) wb(5'(i + 1), 32'(i * 3 + 1));
    wb(5'd8, 32'd101);
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_reg = 5'd3; cfg_val = 32'hDEAD;
    tick();
    cfg_we = 1'b0;
    wb_trig(5'd20, 32'hABCD);
    wait_result("saturate");

    // Two wrong entries out of four.
    do_reset();
    cfg(3'd0, 5'd1, 32'd10);
    cfg(3'd1, 5'd2, 32'd11);
    cfg(3'd2, 5'd3, 32'd12);
    cfg(3'd3, 5'd4, 32'd13);
    arm(4'd4, 5'd20, 32'd1, s);
    wb(5'd1, 32'd10);
    wb(5'd2, 32'd99);
    wb(5'd3, 32'd12);
    wb(5'd4, 32'd77);
    wb_trig(5'd20, 32'd1);
    wait_result("multi_fail");

    // Reset during CHECK, then re-arm with no checks.
    basic_setup(32'd1, s);
    wb(5'd20, 32'd1);
    tick();
    check_eq("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    check_idle_outputs("midrun_rst");
    rst = 1'b1;
    model_clear();
    arm(4'd0, 5'd20, 32'd1, s);
    wb_trig(5'd20, 32'd1);
    wait_result("num_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/asm_result_monitor.md
Name: asm_result_monitor

Overview:
Synthesizable, parametrised checker for CPU assembly tests. It snoops the CPU register-file writeback port and keeps a shadow register file. Once armed, it waits for a trigger register to reach a trigger value, then compares up to NUM_CHECKS programmed (register, expected value) pairs, one per cycle. It reports pass, fail or timeout, so the same check runs in simulation benches and on the FPGA (result driven to LEDs/UART).

Parameters:
XLEN, 32, register/data width
NUM_REGS, 32, architectural registers; address width is $clog2(NUM_REGS)
NUM_CHECKS, 8, max expected-value entries; index width is $clog2(NUM_CHECKS)
TIMEOUT_CYCLES, 100, cycles allowed from arm to trigger; 0 disables timeout

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
wb_en  in  1  CPU register-file write enable
wb_addr  in  RA  CPU register-file write address
wb_data  in  XLEN  CPU register-file write data
cfg_we  in  1  write one check entry (accepted only in IDLE)
cfg_idx  in  CI  check entry index
cfg_reg  in  RA  register to check
cfg_val  in  XLEN  expected value
cfg_num  in  CI+1  number of active checks, 0..NUM_CHECKS (sampled at start)
trig_reg  in  RA  trigger register (sampled at start)
trig_val  in  XLEN  trigger value (sampled at start)
start  in  1  arm pulse (accepted only in IDLE)
busy  out  1  high in WAIT_TRIG or CHECK
done  out  1  sticky; high in PASS, FAIL, TIMEOUT
pass  out  1  high in PASS only
timeout  out  1  high in TIMEOUT only
fail_idx  out  CI  first failing check index
fail_got  out  XLEN  shadow value read at the first failing check

Behaviour:
- Reset: all outputs are 0. Shadow RF, check table and counters clear to 0. State is IDLE.
- Shadow RF: shadow[wb_addr] <= wb_data on posedge when wb_en=1 and wb_addr!=0. x0 always reads 0. Shadow updates in IDLE and WAIT_TRIG and freezes from CHECK onward. The snapshot is taken at trigger.
- IDLE: cfg_we writes entry cfg_idx. cfg_idx >= NUM_CHECKS is ignored. start latches cfg_num (saturates at NUM_CHECKS), trig_reg and trig_val, clears the timeout counter, and moves to WAIT_TRIG. If cfg_we and start occur in the same cycle, the entry is written and is used by this run.
- WAIT_TRIG: match = (shadow[trig_reg] == trig_val), evaluated on registered shadow contents. A writeback arriving in cycle N can therefore match in cycle N+1. On match, go to CHECK with check index 0. Otherwise the counter increments. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without a match, go to TIMEOUT. If match and timeout occur in the same cycle, match wins.
- CHECK: one entry per cycle. Compare shadow[reg[i]] to val[i]. On mismatch, latch fail_idx=i and fail_got, then go to FAIL. If i == num-1 with no mismatch, go to PASS. If num=0, go directly to PASS one cycle after trigger.
- PASS, FAIL, TIMEOUT: terminal. Outputs hold. cfg_we and start are ignored. Only reset returns to IDLE.
- start, cfg_we outside IDLE: ignored, no side effects.
- Reset mid-run: state returns to IDLE next posedge. All results and shadow contents are lost.
- Latency: with trigger detected at cycle T, PASS is visible at cycle T+num.

Optional Feature:
Macro: ASM_MON_ALL_CHECKS_EN.
- Defined: CHECK does not stop at the first mismatch. All num entries run. An extra output fail_mask [NUM_CHECKS-1:0] sets bit i per mismatch and resets to 0. fail_idx/fail_got still report the lowest failing index. PASS or FAIL is decided after entry num-1; done is at T+num regardless.
- Not defined: stop at first mismatch; no fail_mask port.

Decomposition:
- Package asm_mon_pkg:
  - state enum IDLE, WAIT_TRIG, CHECK, PASS, FAIL, TIMEOUT
  - check_entry_t struct {reg, val}
  - width helper constants RA and CI
- One natural sub-module: asm_mon_shadow_rf. It is the write-port-snooping shadow register file with two combinational read ports (trigger and check) and a freeze input.

Test Plan:
- Basic pass: program x25=0 and x13=1 (num=2), trigger x20==1. CPU writes x13=1, x25=0, then x20=1 -> PASS at T+2, pass=1, timeout=0.
- First fail: same setup but x13 written 5 -> FAIL, fail_idx=1, fail_got=5. Further writes to x13 do not change fail_got.
- Timeout: TIMEOUT_CYCLES=100, x20 never written -> timeout=1 exactly 100 cycles after start, done=1, pass=0. Writing x20=1 in the final cycle gives PASS, not TIMEOUT.
- x0 and freeze: a write of 7 to x0 and a check x0==0 -> PASS. A write to a checked register in the cycle after trigger is ignored by CHECK.
- Reset mid-run: rst=0 during CHECK -> next cycle all outputs 0, state IDLE. Re-arming with num=0 -> PASS one cycle after trigger.
- ASM_MON_ALL_CHECKS_EN: 4 checks with entries 1 and 3 wrong -> fail_mask=4'b1010, fail_idx=1, done at T+4.
